br_counter_incr_wrap_sat: RTL
=============================

Name: br_counter_incr_wrap_sat

Overview:
- Up-counting companion to the decrementing counter: counts from a reinit value toward MaxValue by a variable increment per cycle.
- On overflow it either wraps modulo (MaxValue+1) or saturates at MaxValue.
- Exposes the registered value, the combinational next value, and a registered overflow pulse.
- Used for occupancy/credit-return tracking and event counting in datapath control blocks.

Parameters:
- MaxValue, default 1: largest representable count; must be >= 1.
- MaxIncrement, default 1: largest legal incr; must be >= 1 and <= MaxValue (elaboration error otherwise).
- ResetValue, default 0: value loaded on reset; must be <= MaxValue (elaboration error otherwise).
- EnableReinitAndIncr, default 1: 1 = an incr in a reinit cycle is applied on top of initial_value; 0 = incr is ignored in reinit cycles.
- EnableSaturate, default 0: 1 = clamp at MaxValue; 0 = wrap modulo (MaxValue+1).
- Derived ValueWidth = $clog2(MaxValue+1); IncrementWidth = $clog2(MaxIncrement+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- reinit  input  1  load initial_value on next edge.
- initial_value  input  ValueWidth  reinit load value; must be <= MaxValue.
- incr_valid  input  1  qualifies incr.
- incr  input  IncrementWidth  increment amount; must be <= MaxIncrement.
- value  output  ValueWidth  registered count.
- value_next  output  ValueWidth  combinational value to be loaded at next edge.
- overflow  output  1  registered pulse: previous cycle's update exceeded MaxValue.

Behaviour:
- Reset (async assert, any time): value = ResetValue, overflow = 0 immediately; reset mid-operation discards any pending update.
- eff_incr = incr_valid ? incr : 0.
- Overflow arithmetic uses a ValueWidth+1 bit sum: sum = base + eff_incr; ovf = sum > MaxValue.
  - Wrap mode: result = ovf ? sum - (MaxValue+1) : sum. A single subtraction suffices because MaxIncrement <= MaxValue.
  - Saturate mode: result = ovf ? MaxValue : sum.
- Next-value selection, priority reinit > incr:
  - reinit=1, EnableReinitAndIncr=1: value_next = adjust(initial_value, eff_incr).
  - reinit=1, EnableReinitAndIncr=0: value_next = initial_value; incr dropped, ovf=0.
  - reinit=0: value_next = adjust(value, eff_incr).
- value_next == value whenever !incr_valid && !reinit, or incr_valid with incr==0 and no reinit.
- value <= value_next every cycle out of reset; latency 1 cycle from incr to value.
- overflow <= ovf of the selected path; high for exactly one cycle per overflowing update. Also set in saturate mode when value==MaxValue and eff_incr>0.
- incr==0 with incr_valid=1 is legal and never overflows.
- Boundaries:
  - value==MaxValue, incr=1: wrap -> 0; saturate -> MaxValue. overflow=1 in both.
  - sum == MaxValue exactly: no overflow.
- Invariants (assert): value <= MaxValue always; overflow never high in the cycle after reset deassertion.
- Assumptions (checked by integration assertions): initial_value <= MaxValue, incr <= MaxIncrement.
- No handshake backpressure; the counter accepts an update every cycle.

Test Plan:
- Reset with ResetValue=2, MaxValue=5 -> value=2, overflow=0 immediately, before any clk edge.
- Wrap mode, MaxValue=5, value=4, incr_valid=1 incr=3 -> next cycle value=1, overflow=1 for one cycle; then incr_valid=0 -> value holds 1, overflow=0.
- Saturate mode, MaxValue=5, value=4, incr=3 -> value=5, overflow=1; repeat incr=1 -> value=5, overflow=1; incr=0 with incr_valid=1 -> value=5, overflow=0.
- reinit with initial_value=3, incr=2, EnableReinitAndIncr=1 -> value=5, overflow=0; same stimulus with EnableReinitAndIncr=0 -> value=3.
- Exact boundary, MaxValue=7, value=5, incr=2 -> value=7, overflow=0; value_next equals the value observed one cycle later in every cycle of a random incr stream.
- Assert rst asynchronously mid-stream between edges, with value=6 and incr pending -> value=ResetValue and overflow=0 at once; counting resumes correctly after deassertion.

Source files
------------

// File: rtl/br_counter_incr_wrap_sat.sv
// Up-counter with a variable per-cycle increment that either wraps modulo (MaxValue+1)
// or saturates at MaxValue, exposing the registered count, its next value and an overflow pulse.
module br_counter_incr_wrap_sat #(
    parameter int unsigned MaxValue            = 1,
    parameter int unsigned MaxIncrement        = 1,
    parameter int unsigned ResetValue          = 0,
    parameter bit          EnableReinitAndIncr = 1'b1,
    parameter bit          EnableSaturate      = 1'b0,
    localparam int unsigned ValueWidth         = $clog2(MaxValue + 1),
    localparam int unsigned IncrementWidth     = $clog2(MaxIncrement + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reinit,
    input  logic [ValueWidth-1:0]     initial_value,
    input  logic                      incr_valid,
    input  logic [IncrementWidth-1:0] incr,
    output logic [ValueWidth-1:0]     value,
    output logic [ValueWidth-1:0]     value_next,
    output logic                      overflow
);

    // One extra bit holds any base + increment without losing the carry.
    localparam int unsigned SumWidth = ValueWidth + 1;

    localparam logic [SumWidth-1:0]   MaxSum  = SumWidth'(MaxValue);
    localparam logic [SumWidth-1:0]   Modulus = SumWidth'(MaxValue + 1);
    localparam logic [ValueWidth-1:0] MaxVal  = ValueWidth'(MaxValue);
    localparam logic [ValueWidth-1:0] RstVal  = ValueWidth'(ResetValue);

    if (MaxValue < 1) begin : g_bad_max_value
        $error("MaxValue must be >= 1");
    end
    if (MaxIncrement < 1 || MaxIncrement > MaxValue) begin : g_bad_max_increment
        $error("MaxIncrement must be in [1, MaxValue]");
    end
    if (ResetValue > MaxValue) begin : g_bad_reset_value
        $error("ResetValue must be <= MaxValue");
    end

    logic [ValueWidth-1:0]     r_value;
    logic                      r_overflow;

    logic [IncrementWidth-1:0] w_eff_incr;
    logic [IncrementWidth-1:0] w_addend;
    logic [ValueWidth-1:0]     w_base;
    logic [SumWidth-1:0]       w_sum;
    logic                      w_ovf;
    logic [ValueWidth-1:0]     w_next;

    // Next-value selection: reinit takes priority over the running count.
    always_comb begin
        w_eff_incr = incr_valid ? incr : '0;
        w_base     = reinit ? initial_value : r_value;
        w_addend   = (reinit && !EnableReinitAndIncr) ? '0 : w_eff_incr;
        w_sum      = SumWidth'(w_base) + SumWidth'(w_addend);
        w_ovf      = (w_sum > MaxSum);
        w_next     = w_sum[ValueWidth-1:0];
        if (w_ovf) begin
            // A single subtraction is enough since the increment never exceeds MaxValue.
            w_next = EnableSaturate ? MaxVal : ValueWidth'(w_sum - Modulus);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value    <= RstVal;
            r_overflow <= 1'b0;
        end else begin
            r_value    <= w_next;
            r_overflow <= w_ovf;
        end
    end

    assign value      = r_value;
    assign value_next = w_next;
    assign overflow   = r_overflow;

    a_value_in_range: assert property (@(posedge clk) disable iff (rst) r_value <= MaxVal);
    a_no_ovf_after_reset: assert property (@(posedge clk) $fell(rst) |-> !r_overflow);
    a_initial_value_legal: assert property (@(posedge clk) disable iff (rst)
        reinit |-> (initial_value <= MaxVal));
    a_incr_legal: assert property (@(posedge clk) disable iff (rst)
        incr_valid |-> (SumWidth'(incr) <= SumWidth'(MaxIncrement)));

endmodule
